// File: rtl/cpu_pkg.sv
// Shared definitions for the memory stage: stack FSM states, address and
// write-source encodings, the default stack pointer and the frame word count.
package cpu_pkg;

    localparam logic [15:0] SP_RESET_DEFAULT = 16'h07FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WORD2 = 2'd1,
        WORD3 = 2'd2
    } stack_state_e;

    typedef enum logic [1:0] {
        ADDR_RESULT = 2'b00,
        ADDR_SP     = 2'b01,
        ADDR_SP_INC = 2'b10,
        ADDR_NONE   = 2'b11
    } addr_sel_e;

    typedef enum logic [1:0] {
        WSRC_RDEST     = 2'b00,
        WSRC_CALL      = 2'b01,
        WSRC_INT       = 2'b10,
        WSRC_RDEST_ALT = 2'b11
    } wsrc_e;

    // Words moved by a push/pop for a given write-source code.
    function automatic logic [1:0] word_count(input logic [1:0] wsrc);
        case (wsrc)
            WSRC_CALL: return 2'd2;
            WSRC_INT:  return 2'd3;
            default:   return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Stack pointer and multi-word push/pop sequencing for CALL/INT/RET/RTI frames.
// push and pop arrive already conflict-resolved (never both high).
module stack_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [1:0]  write_src_select,
    input  logic [15:0] read_data1,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus_one,
    input  logic [2:0]  flags_in,
    input  logic [15:0] dmem_rdata,
    output logic [15:0] sp,
    output logic [15:0] stack_wdata,
    output logic        stall,
    output logic        pop_done_pc,
    output logic        pop_done_flags,
    output logic [31:0] frame_pc,
    output logic [2:0]  frame_flags,
    output logic [1:0]  state_dbg
);

    stack_state_e state;
    logic [15:0]  sp_q;
    logic [15:0]  pc_lo_q;
    logic [15:0]  pc_hi_q;
    logic [1:0]   wc;
    logic         op;
    logic         last_word;

    assign wc        = word_count(write_src_select);
    assign op        = push | pop;
    assign last_word = (wc == 2'd1) || (state == WORD2 && wc == 2'd2) || (state == WORD3);

    assign stall          = reset & op & ~last_word;
    assign pop_done_pc    = pop & (wc != 2'd1) & last_word;
    assign pop_done_flags = pop & (wc == 2'd3) & (state == WORD3);
    assign sp             = sp_q;
    assign state_dbg      = state;

    // Pop order is PC low, PC high, flags: the final word completes the frame.
    assign frame_pc    = (wc == 2'd3) ? {pc_hi_q, pc_lo_q} : {dmem_rdata, pc_lo_q};
    assign frame_flags = dmem_rdata[2:0];

    always_comb begin
        stack_wdata = read_data1;
        case (wc)
            2'd2: stack_wdata = (state == IDLE) ? pc_plus_one[31:16] : pc_plus_one[15:0];
            2'd3: begin
                case (state)
                    IDLE:    stack_wdata = {13'd0, flags_in};
                    WORD2:   stack_wdata = pc[31:16];
                    default: stack_wdata = pc[15:0];
                endcase
            end
            default: stack_wdata = read_data1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sp_q    <= SP_RESET;
            pc_lo_q <= '0;
            pc_hi_q <= '0;
        end else begin
            if (op) sp_q <= push ? sp_q - 16'd1 : sp_q + 16'd1;
            if (pop && state == IDLE)  pc_lo_q <= dmem_rdata;
            if (pop && state == WORD2) pc_hi_q <= dmem_rdata;
            case (state)
                IDLE:    if (op && wc != 2'd1) state <= WORD2;
                WORD2:   state <= (wc == 2'd3) ? WORD3 : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: data memory port, stack frame sequencing and the MEM/WB
// register. Stalled cycles load a bubble into MEM/WB while EX/MEM is held upstream.
module memory_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] result_in,
    input  logic [15:0] read_data1,
    input  logic [31:0] PC,
    input  logic [31:0] pc_plus_one,
    input  logic [2:0]  flags_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_push,
    input  logic        mem_pop,
    input  logic [1:0]  memory_address_select,
    input  logic [1:0]  memory_write_src_select,
    input  logic        reg_write,
    input  logic [1:0]  wb_sel,
    input  logic [2:0]  reg_write_address,
    input  logic        pc_choose_memory,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    output logic        dmem_we,
    input  logic [15:0] dmem_rdata,
    output logic        mem_stall,
    output logic [15:0] mem_data_out,
    output logic [15:0] result_out,
    output logic        reg_write_out,
    output logic [1:0]  wb_sel_out,
    output logic [2:0]  reg_write_address_out,
    output logic        pc_choose_memory_out,
    output logic [31:0] popped_pc_out,
    output logic [2:0]  popped_flags_out,
    output logic [15:0] sp_out,
    output logic [1:0]  state_dbg
);

    logic        push, pop, store, load, write_cycle, read_cycle;
    logic [15:0] sp, stack_wdata;
    logic        stall, pop_done_pc, pop_done_flags;
    logic [31:0] frame_pc;
    logic [2:0]  frame_flags;

    // Push beats pop, write beats read; a stack op suppresses plain load/store.
    assign push        = mem_push;
    assign pop         = mem_pop & ~mem_push;
    assign store       = mem_write & ~(mem_push | mem_pop);
    assign load        = mem_read & ~mem_write & ~(mem_push | mem_pop);
    assign write_cycle = push | store;
    assign read_cycle  = pop | load;

    stack_sequencer #(.SP_RESET(SP_RESET)) u_seq (
        .clk              (clk),
        .reset            (reset),
        .push             (push),
        .pop              (pop),
        .write_src_select (memory_write_src_select),
        .read_data1       (read_data1),
        .pc               (PC),
        .pc_plus_one      (pc_plus_one),
        .flags_in         (flags_in),
        .dmem_rdata       (dmem_rdata),
        .sp               (sp),
        .stack_wdata      (stack_wdata),
        .stall            (stall),
        .pop_done_pc      (pop_done_pc),
        .pop_done_flags   (pop_done_flags),
        .frame_pc         (frame_pc),
        .frame_flags      (frame_flags),
        .state_dbg        (state_dbg)
    );

    always_comb begin
        dmem_addr = result_in;
        case (memory_address_select)
            ADDR_SP:     dmem_addr = sp;
            ADDR_SP_INC: dmem_addr = sp + 16'd1;
            default:     dmem_addr = result_in;
        endcase
    end

    assign dmem_wdata = push ? stack_wdata : read_data1;
    assign dmem_we    = reset & write_cycle & (memory_address_select != ADDR_NONE);
    assign mem_stall  = stall;
    assign sp_out     = sp;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_data_out          <= '0;
            result_out            <= '0;
            reg_write_out         <= 1'b0;
            wb_sel_out            <= '0;
            reg_write_address_out <= '0;
            pc_choose_memory_out  <= 1'b0;
            popped_pc_out         <= '0;
            popped_flags_out      <= '0;
        end else if (stall) begin
            reg_write_out        <= 1'b0;
            pc_choose_memory_out <= 1'b0;
        end else begin
            result_out            <= result_in;
            reg_write_out         <= reg_write;
            wb_sel_out            <= wb_sel;
            reg_write_address_out <= reg_write_address;
            pc_choose_memory_out  <= pc_choose_memory;
            if (read_cycle)     mem_data_out     <= dmem_rdata;
            if (pop_done_pc)    popped_pc_out    <= frame_pc;
            if (pop_done_flags) popped_flags_out <= frame_flags;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed frame/boundary scenarios plus random traffic,
// checked against a transaction-level stack/memory model through an expected queue.
`timescale 1ns/1ps
module tb_memory_stage;

    localparam int K_PUSH = 0, K_POP = 1, K_STORE = 2, K_LOAD = 3, K_RW = 4,
                   K_PUSHPOP = 5, K_STORE_NONE = 6;
    localparam logic [15:0] SP_INIT = 16'h07FF;

    logic        clk, reset;
    logic [15:0] result_in, read_data1;
    logic [31:0] PC, pc_plus_one;
    logic [2:0]  flags_in;
    logic        mem_read, mem_write, mem_push, mem_pop;
    logic [1:0]  memory_address_select, memory_write_src_select;
    logic        reg_write, pc_choose_memory;
    logic [1:0]  wb_sel;
    logic [2:0]  reg_write_address;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_we, mem_stall;
    logic [15:0] mem_data_out, result_out, sp_out;
    logic        reg_write_out, pc_choose_memory_out;
    logic [1:0]  wb_sel_out, state_dbg;
    logic [2:0]  reg_write_address_out, popped_flags_out;
    logic [31:0] popped_pc_out;

    memory_stage dut (
        .clk(clk), .reset(reset), .result_in(result_in), .read_data1(read_data1),
        .PC(PC), .pc_plus_one(pc_plus_one), .flags_in(flags_in),
        .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
        .memory_address_select(memory_address_select),
        .memory_write_src_select(memory_write_src_select),
        .reg_write(reg_write), .wb_sel(wb_sel), .reg_write_address(reg_write_address),
        .pc_choose_memory(pc_choose_memory),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .mem_data_out(mem_data_out), .result_out(result_out),
        .reg_write_out(reg_write_out), .wb_sel_out(wb_sel_out),
        .reg_write_address_out(reg_write_address_out), .pc_choose_memory_out(pc_choose_memory_out),
        .popped_pc_out(popped_pc_out), .popped_flags_out(popped_flags_out), .sp_out(sp_out),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // data memory attached to the port
    logic [15:0] mem [0:65535];
    assign dmem_rdata = mem[dmem_addr];
    always @(posedge clk) if (dmem_we) mem[dmem_addr] <= dmem_wdata;

    // reference model state
    logic [15:0] ref_mem [0:65535];
    logic [15:0] ref_sp, ref_mdata;
    logic [31:0] ref_pc;
    logic [2:0]  ref_flags;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] mdata;
        logic [15:0] sp;
        logic [31:0] ppc;
        logic [2:0]  pfl;
        logic [2:0]  rwa;
        logic [1:0]  wbs;
        logic        pcm;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h expected=%h", name, act, exp);
    endtask

    function automatic int ref_words(input logic [1:0] wsrc);
        if (wsrc == 2'b01) return 2;
        if (wsrc == 2'b10) return 3;
        return 1;
    endfunction

    task automatic idle_inputs();
        mem_push = 0; mem_pop = 0; mem_read = 0; mem_write = 0;
        reg_write = 0; pc_choose_memory = 0; memory_address_select = 2'b11;
    endtask

    task automatic reset_model();
        ref_sp = SP_INIT; ref_mdata = '0; ref_pc = '0; ref_flags = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0;
        idle_inputs();
        reset_model();
        @(negedge clk);
        reset = 1;
    endtask

    // driver: issue one EX/MEM transaction at a negedge, hold through stalls
    task automatic issue(input int kind, input logic [1:0] wsrc, input logic [15:0] addr,
                         input logic [15:0] data, input logic [31:0] pcv,
                         input logic [31:0] ppo, input logic [2:0] fl);
        int w, stalls;
        bit last, is_push, is_pop;
        logic [15:0] words [3];
        logic [15:0] rd [3];
        logic [2:0] rwa;
        logic [1:0] wbs;
        logic pcm;
        rwa = 3'($urandom_range(0, 7));
        wbs = 2'($urandom_range(0, 3));
        pcm = 1'($urandom_range(0, 1));
        is_push = (kind == K_PUSH) || (kind == K_PUSHPOP);
        is_pop  = (kind == K_POP);
        w = (is_push || is_pop) ? ref_words(wsrc) : 1;

        mem_push  = is_push;
        mem_pop   = (kind == K_POP) || (kind == K_PUSHPOP);
        mem_write = (kind == K_STORE) || (kind == K_RW) || (kind == K_STORE_NONE);
        mem_read  = (kind == K_LOAD) || (kind == K_RW);
        memory_address_select = is_push ? 2'b01 : is_pop ? 2'b10 :
                                (kind == K_STORE_NONE) ? 2'b11 : 2'b00;
        memory_write_src_select = wsrc;
        result_in = addr; read_data1 = data; PC = pcv; pc_plus_one = ppo; flags_in = fl;
        reg_write = 1; wb_sel = wbs; reg_write_address = rwa; pc_choose_memory = pcm;

        if (is_push) begin
            case (wsrc)
                2'b01: begin words[0] = ppo[31:16]; words[1] = ppo[15:0]; end
                2'b10: begin words[0] = {13'd0, fl}; words[1] = pcv[31:16]; words[2] = pcv[15:0]; end
                default: words[0] = data;
            endcase
            for (int i = 0; i < w; i++) begin
                ref_mem[ref_sp] = words[i];
                ref_sp = ref_sp - 16'd1;
            end
        end else if (is_pop) begin
            for (int i = 0; i < w; i++) begin
                ref_sp = ref_sp + 16'd1;
                rd[i] = ref_mem[ref_sp];
            end
            ref_mdata = rd[w-1];
            if (w >= 2) ref_pc = {rd[1], rd[0]};
            if (w == 3) ref_flags = rd[2][2:0];
        end else if (kind == K_STORE || kind == K_RW) begin
            ref_mem[addr] = data;
        end else if (kind == K_LOAD) begin
            ref_mdata = ref_mem[addr];
        end
        exp_q.push_back('{res: addr, mdata: ref_mdata, sp: ref_sp, ppc: ref_pc,
                          pfl: ref_flags, rwa: rwa, wbs: wbs, pcm: pcm});

        stalls = 0;
        last = 0;
        for (int c = 0; c < 6 && !last; c++) begin
            #1;
            if (mem_stall) stalls++; else last = 1;
            @(negedge clk);
        end
        check("op_completed", 32'(last), 32'd1);
        check("stall_cycles", stalls, w - 1);
        idle_inputs();
    endtask

    // monitor: one MEM/WB result per completed transaction
    always @(negedge clk) begin
        if (reset === 1'b1 && reg_write_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_result_out", result_out, e.res);
                check("mon_mem_data_out", mem_data_out, e.mdata);
                check("mon_sp_out", sp_out, e.sp);
                check("mon_popped_pc", popped_pc_out, e.ppc);
                check("mon_popped_flags", popped_flags_out, e.pfl);
                check("mon_rwa", reg_write_address_out, e.rwa);
                check("mon_wb_sel", wb_sel_out, e.wbs);
                check("mon_pc_choose", pc_choose_memory_out, e.pcm);
            end
        end
    end

    initial begin
        int mism;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        reset = 0;
        idle_inputs();
        result_in = 16'h1234; read_data1 = 16'h5555; PC = 32'h1; pc_plus_one = 32'h2; flags_in = 3'b111;
        wb_sel = 2'b11; reg_write_address = 3'b111;
        // strobes active under reset must not stall or write
        mem_push = 1; reg_write = 1; pc_choose_memory = 1;
        memory_address_select = 2'b01; memory_write_src_select = 2'b10;
        reset_model();
        repeat (2) @(negedge clk);
        check("rst_sp_out", sp_out, SP_INIT);
        check("rst_state", state_dbg, 2'd0);
        check("rst_mem_stall", mem_stall, 1'b0);
        check("rst_dmem_we", dmem_we, 1'b0);
        check("rst_reg_write_out", reg_write_out, 1'b0);
        check("rst_result_out", result_out, 16'h0);
        check("rst_popped_pc", popped_pc_out, 32'h0);
        check("rst_wb_sel_out", wb_sel_out, 2'b00);
        idle_inputs();
        reset = 1;

        // one-word push
        issue(K_PUSH, 2'b00, 16'h0000, 16'hABCD, 32'h0, 32'h0, 3'b000);
        check("push1_mem", mem[16'h07FF], 16'hABCD);
        check("push1_sp", sp_out, 16'h07FE);

        // CALL frame
        do_reset();
        issue(K_PUSH, 2'b01, 16'h0003, 16'h0, 32'h0, 32'h0001_0020, 3'b000);
        check("call_mem_hi", mem[16'h07FF], 16'h0001);
        check("call_mem_lo", mem[16'h07FE], 16'h0020);
        check("call_sp", sp_out, 16'h07FD);

        // INT then RTI
        do_reset();
        issue(K_PUSH, 2'b10, 16'h0004, 16'h0, 32'h0000_0044, 32'h0, 3'b101);
        issue(K_POP, 2'b10, 16'h0005, 16'h0, 32'h0, 32'h0, 3'b000);
        check("rti_popped_pc", popped_pc_out, 32'h0000_0044);
        check("rti_popped_flags", popped_flags_out, 3'b101);
        check("rti_sp", sp_out, 16'h07FF);

        // store/load and write-beats-read
        issue(K_STORE, 2'b01, 16'h0010, 16'h1234, 32'h0, 32'h0, 3'b000);
        issue(K_LOAD, 2'b10, 16'h0010, 16'h0, 32'h0, 32'h0, 3'b000);
        check("load_data", mem_data_out, 16'h1234);
        issue(K_RW, 2'b00, 16'h0010, 16'h5678, 32'h0, 32'h0, 3'b000);
        check("rw_write", mem[16'h0010], 16'h5678);
        check("rw_hold", mem_data_out, 16'h1234);
        issue(K_STORE_NONE, 2'b00, 16'h0020, 16'h9999, 32'h0, 32'h0, 3'b000);
        check("no_access_store", mem[16'h0020], 16'h0000);

        // reset in WORD2 of a CALL
        do_reset();
        mem_push = 1; memory_address_select = 2'b01; memory_write_src_select = 2'b01;
        pc_plus_one = 32'h0001_0020; reg_write = 1;
        @(negedge clk);
        ref_mem[SP_INIT] = 16'h0001;
        check("abort_in_word2", state_dbg, 2'd1);
        reset = 0;
        #1;
        check("abort_state", state_dbg, 2'd0);
        check("abort_sp", sp_out, SP_INIT);
        check("abort_stall", mem_stall, 1'b0);
        @(negedge clk);
        check("abort_word_kept", mem[SP_INIT], 16'h0001);
        idle_inputs();
        reset_model();
        reset = 1;

        // walk SP down to 0000, then wrap
        for (int i = 0; i < 2047; i++)
            issue(K_PUSH, 2'b00, 16'($urandom), 16'($urandom), 32'h0, 32'h0, 3'b000);
        check("walk_sp", sp_out, 16'h0000);
        issue(K_PUSH, 2'b11, 16'h0, 16'hBEEF, 32'h0, 32'h0, 3'b000);
        check("wrap_push_mem", mem[16'h0000], 16'hBEEF);
        check("wrap_push_sp", sp_out, 16'hFFFF);
        issue(K_POP, 2'b00, 16'h0, 16'h0, 32'h0, 32'h0, 3'b000);
        check("wrap_pop_sp", sp_out, 16'h0000);
        check("wrap_pop_data", mem_data_out, 16'hBEEF);

        // random traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            issue($urandom_range(0, 6), 2'($urandom_range(0, 3)), 16'($urandom_range(0, 63)),
                  16'($urandom), $urandom, $urandom, 3'($urandom_range(0, 7)));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        mism = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) mism++;
        check("memory_image", mism, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
